// File: rtl/seg7_pkg.sv
// Shared types and the active-low hex-to-7-segment table for the scan driver.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_OFF = 7'h7F;

    // Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
    function automatic seg7_t hex7seg(input logic [3:0] nib);
        seg7_t seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h18;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot counter (cnt) and digit index (idx) for the display scan.
// Exposes next-cycle values so the driver can register its outputs against them.
module seg7_scan_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int SLOT       = 10,
    parameter int CNT_W      = $clog2(SLOT),
    parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] cnt_next,
    output logic [IDX_W-1:0] idx_next,
    output logic             slot_start,
    output logic             frame_end
);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    // slot_start marks the last cycle of a slot, i.e. the next cycle opens a new slot.
    assign slot_start = (cnt == CNT_W'(SLOT - 1));
    assign frame_end  = slot_start && (idx == IDX_W'(NUM_DIGITS - 1));

    always_comb begin
        cnt_next = slot_start ? '0 : cnt + CNT_W'(1);
        idx_next = idx;
        if (slot_start)
            idx_next = frame_end ? '0 : idx + IDX_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_next;
            idx <= idx_next;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-synchronous shadowing.
// Optional SEG7_BRIGHTNESS_EN adds a brightness_i port that shortens the lit window per slot.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_HZ     = 125_000_000,
    parameter int REFRESH_HZ = 10_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    blank_lz_i,
`ifdef SEG7_BRIGHTNESS_EN
    input  logic [3:0]              brightness_i,
`endif
    output logic [NUM_DIGITS-1:0]   digit_en_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic                    frame_o
);

    localparam int SLOT  = CLK_HZ / REFRESH_HZ;
    localparam int CNT_W = $clog2(SLOT);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("seg7_scan_driver: NUM_DIGITS must be 2..8");
    end
    if (SLOT < 4) begin : g_bad_slot
        $error("seg7_scan_driver: CLK_HZ/REFRESH_HZ must be >= 4");
    end
`ifdef SEG7_BRIGHTNESS_EN
    if (SLOT < 16) begin : g_bad_bright_slot
        $error("seg7_scan_driver: brightness control needs CLK_HZ/REFRESH_HZ >= 16");
    end
`endif

    logic [CNT_W-1:0]        cnt_next;
    logic [IDX_W-1:0]        idx_next;
    logic                    slot_start;
    logic                    frame_end;

    logic [4*NUM_DIGITS-1:0] shadow_value, value_nx;
    logic [NUM_DIGITS-1:0]   shadow_dp, dp_nx;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    all_zero;
    logic                    lit;
    logic [3:0]              nib;
    logic [NUM_DIGITS-1:0]   digit_en_nx;
    seg7_t                   seg_nx;
    logic                    dp_out_nx;

    seg7_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SLOT       (SLOT)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_next   (cnt_next),
        .idx_next   (idx_next),
        .slot_start (slot_start),
        .frame_end  (frame_end)
    );

`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0] shadow_bri, bri_nx;
    int         lit_prod;
    int         lit_limit;

    assign bri_nx = frame_end ? brightness_i : shadow_bri;

    always_comb begin
        lit_prod  = ((int'(bri_nx) + 1) * SLOT) >>> 4;
        lit_limit = (lit_prod < 2) ? 2 : lit_prod;
        lit       = !slot_start && (int'(cnt_next) < lit_limit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         shadow_bri <= '0;
        else if (frame_end) shadow_bri <= brightness_i;
    end
`else
    assign lit = !slot_start;
`endif

    assign value_nx = frame_end ? value_i : shadow_value;
    assign dp_nx    = frame_end ? dp_i    : shadow_dp;

    // Digit k>0 blanks when it and every more-significant nibble are zero.
    always_comb begin
        blank_mask = '0;
        all_zero   = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (value_nx[4*k +: 4] != 4'h0) all_zero = 1'b0;
            blank_mask[k] = blank_lz_i && (k != 0) && all_zero;
        end
    end

    always_comb begin
        nib         = value_nx[4*idx_next +: 4];
        digit_en_nx = '1;
        seg_nx      = SEG_OFF;
        dp_out_nx   = 1'b1;
        if (lit) begin
            for (int k = 0; k < NUM_DIGITS; k++)
                digit_en_nx[k] = (idx_next != IDX_W'(k));
            seg_nx    = blank_mask[idx_next] ? SEG_OFF : hex7seg(nib);
            dp_out_nx = ~dp_nx[idx_next];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
        end else if (frame_end) begin
            shadow_value <= value_i;
            shadow_dp    <= dp_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_en_o <= '1;
            seg_o      <= SEG_OFF;
            dp_o       <= 1'b1;
            frame_o    <= 1'b0;
        end else begin
            digit_en_o <= digit_en_nx;
            seg_o      <= seg_nx;
            dp_o       <= dp_out_nx;
            frame_o    <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits and a 10-clock slot.
module tb_seg7_scan_driver;

    localparam int NUM_DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value_i;
    logic [3:0]  dp_i;
    logic        blank_lz_i;
    logic [3:0]  digit_en_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic        frame_o;

    int checks   = 0;
    int failures = 0;
    int edges    = 0;

    seg7_scan_driver #(
        .NUM_DIGITS (NUM_DIGITS),
        .CLK_HZ     (1000),
        .REFRESH_HZ (100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_i    (value_i),
        .dp_i       (dp_i),
        .blank_lz_i (blank_lz_i),
        .digit_en_o (digit_en_o),
        .seg_o      (seg_o),
        .dp_o       (dp_o),
        .frame_o    (frame_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pack(input logic f, input logic d,
                                         input logic [3:0] en, input logic [6:0] seg);
        return {19'b0, f, d, en, seg};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] val, input logic [3:0] dp,
                                 input logic blank);
        value_i    = val;
        dp_i       = dp;
        blank_lz_i = blank;
    endtask

    // Runs to just after edge number 'target' since reset release, watching the anodes every cycle.
    task automatic advanceTo(input int target);
        while (edges < target) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            checkOutput("one_hot_low", 32'($countones(~digit_en_o) <= 1), 32'd1);
        end
    endtask

    task automatic checkAt(input int target, input string tag, input logic [31:0] expected);
        advanceTo(target);
        checkOutput(tag, pack(frame_o, dp_o, digit_en_o, seg_o), expected);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(16'h1234, 4'b0000, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset_state", pack(frame_o, dp_o, digit_en_o, seg_o),
                    pack(1'b0, 1'b1, 4'b1111, 7'h7F));
        rst_n = 1'b1;
        edges = 0;

        checkAt(1,  "first_digit0_shadow0", pack(1'b0, 1'b1, 4'b1110, 7'h40));
        checkAt(10, "dead_slot1",           pack(1'b0, 1'b1, 4'b1111, 7'h7F));
        checkAt(39, "digit3_shadow0",       pack(1'b0, 1'b1, 4'b0111, 7'h40));
        checkAt(40, "frame_pulse",          pack(1'b1, 1'b1, 4'b1111, 7'h7F));
        checkAt(41, "f1_digit0_4",          pack(1'b0, 1'b1, 4'b1110, 7'h19));
        checkAt(51, "f1_digit1_3",          pack(1'b0, 1'b1, 4'b1101, 7'h30));

        advanceTo(65);
        applyStimulus(16'hABCD, 4'b0000, 1'b0);
        checkAt(71,  "f1_digit3_still_1",   pack(1'b0, 1'b1, 4'b0111, 7'h79));
        checkAt(80,  "frame_pulse2",        pack(1'b1, 1'b1, 4'b1111, 7'h7F));
        checkAt(81,  "f2_digit0_D",         pack(1'b0, 1'b1, 4'b1110, 7'h21));
        checkAt(91,  "f2_digit1_C",         pack(1'b0, 1'b1, 4'b1101, 7'h46));
        checkAt(101, "f2_digit2_b",         pack(1'b0, 1'b1, 4'b1011, 7'h03));
        checkAt(111, "f2_digit3_A",         pack(1'b0, 1'b1, 4'b0111, 7'h08));

        applyStimulus(16'hABCD, 4'b0100, 1'b0);
        checkAt(121, "dp_digit0_off",       pack(1'b0, 1'b1, 4'b1110, 7'h21));
        checkAt(140, "dp_dead_cycle_off",   pack(1'b0, 1'b1, 4'b1111, 7'h7F));
        checkAt(141, "dp_digit2_on",        pack(1'b0, 1'b0, 4'b1011, 7'h03));
        checkAt(151, "dp_digit3_off",       pack(1'b0, 1'b1, 4'b0111, 7'h08));

        applyStimulus(16'h0070, 4'b0100, 1'b1);
        checkAt(161, "lz_digit0_0",         pack(1'b0, 1'b1, 4'b1110, 7'h40));
        checkAt(171, "lz_digit1_7",         pack(1'b0, 1'b1, 4'b1101, 7'h78));
        checkAt(181, "lz_digit2_blank_dp",  pack(1'b0, 1'b0, 4'b1011, 7'h7F));
        checkAt(191, "lz_digit3_blank",     pack(1'b0, 1'b1, 4'b0111, 7'h7F));

        applyStimulus(16'h0000, 4'b0000, 1'b1);
        checkAt(201, "lz_zero_digit0",      pack(1'b0, 1'b1, 4'b1110, 7'h40));
        checkAt(211, "lz_zero_digit1",      pack(1'b0, 1'b1, 4'b1101, 7'h7F));
        checkAt(225, "pre_reset_digit2",    pack(1'b0, 1'b1, 4'b1011, 7'h7F));

        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_off", pack(frame_o, dp_o, digit_en_o, seg_o),
                    pack(1'b0, 1'b1, 4'b1111, 7'h7F));
        applyStimulus(16'h0005, 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
        checkAt(1,  "post_reset_digit0",    pack(1'b0, 1'b1, 4'b1110, 7'h40));
        checkAt(41, "post_reset_value5",    pack(1'b0, 1'b1, 4'b1110, 7'h12));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
